// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding an IF/ID pipeline register.
//
// Holds the fetch PC and drives it straight to instruction memory, which answers
// combinationally on M_instruction. Each normal cycle the returned word is latched
// into IF/ID together with its PC. The stage supports decode-side stalls, branch
// redirects that flush the wrong-path word, and a halt opcode that parks fetch
// until reset.
//
// Ports:
//   clk            in   1   sole clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hold PC and IF/ID (level)
//   br_taken       in   1   redirect pulse from execute
//   br_target      in  12   redirect PC, used when br_taken=1
//   M_instruction  in  16   instruction memory read data for PCAdd_pc
//   PCAdd_pc       out 12   current fetch PC
//   ID_instruction out 16   registered IF/ID instruction
//   ID_pc          out 12   PC of ID_instruction
//   ID_valid       out  1   ID_instruction is a real fetched word
//   halted         out  1   fetch stopped by halt opcode
module fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [11:0] br_target,
  input  logic [15:0] M_instruction,
  output logic [11:0] PCAdd_pc,
  output logic [15:0] ID_instruction,
  output logic [11:0] ID_pc,
  output logic        ID_valid,
  output logic        halted
);

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [11:0] r_pc;
  logic [11:0] w_pc_next;
  logic [15:0] r_id_instr;
  logic [15:0] w_id_instr_next;
  logic [11:0] r_id_pc;
  logic [11:0] w_id_pc_next;
  logic        r_id_valid;
  logic        w_id_valid_next;

  logic        w_is_halt;
  logic [11:0] w_pc_inc;

  assign w_is_halt = (M_instruction[15:12] == HALT_OPCODE);
  // 12-bit add wraps naturally from 12'hFFF to 12'h000.
  assign w_pc_inc  = r_pc + 12'd1;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_id_instr_next = r_id_instr;
    w_id_pc_next    = r_id_pc;
    w_id_valid_next = r_id_valid;

    unique case (r_state)
      StRun: begin
        if (br_taken) begin
          // Redirect beats stall and halt: the word at the old PC is wrong-path.
          w_pc_next       = br_target;
          w_id_instr_next = NOP_INSTR;
          w_id_pc_next    = r_pc;
          w_id_valid_next = 1'b0;
        end else if (stall) begin
          // Hold everything; a halt word under stall is seen again next cycle.
        end else begin
          w_id_instr_next = M_instruction;
          w_id_pc_next    = r_pc;
          w_id_valid_next = 1'b1;
          if (w_is_halt) begin
            // PC parks on the halt word.
            w_state_next = StHalted;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end
      StHalted: begin
        // Drain a bubble into decode; stall and br_taken have no effect here.
        w_id_instr_next = NOP_INSTR;
        w_id_valid_next = 1'b0;
      end
      default: begin
        w_state_next = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 12'h000;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_id_instr <= w_id_instr_next;
      r_id_pc    <= w_id_pc_next;
      r_id_valid <= w_id_valid_next;
    end
  end

  assign PCAdd_pc       = r_pc;
  assign ID_instruction = r_id_instr;
  assign ID_pc          = r_id_pc;
  assign ID_valid       = r_id_valid;
  assign halted         = (r_state == StHalted);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, bubble instruction driven into decode.
REQ-003 Parameter HALT_OPCODE, default 4'hF, value of instruction[15:12] that halts fetch.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  decode-side hazard hold (e.g. load-use delay); level-sensitive.
REQ-008 br_taken  input  1  redirect request from execute; single-cycle pulse.
REQ-009 br_target  input  12  redirect PC, sampled when br_taken=1.
REQ-010 M_instruction  input  16  instruction word returned combinationally by instruction memory for PCAdd_pc.
REQ-011 PCAdd_pc  output  12  current fetch PC, driven straight from PC register to instruction memory.
REQ-012 ID_instruction  output  16  registered IF/ID instruction.
REQ-013 ID_pc  output  12  registered PC of ID_instruction.
REQ-014 ID_valid  output  1  ID_instruction is a real fetched instruction, not a bubble.
REQ-015 halted  output  1  fetch stopped by halt opcode.

Function
REQ-016 Two states: RUN, HALTED; halted=1 exactly when state=HALTED.
REQ-017 Fetch latency: instruction at PC p appears on ID_instruction with ID_pc=p one edge after PCAdd_pc=p.
REQ-018 RUN, no stall, no br_taken, opcode != HALT_OPCODE: ID_instruction<=M_instruction, ID_pc<=PCAdd_pc, ID_valid<=1, PC<=PC+1.
REQ-019 PC arithmetic is 12-bit modulo: 12'hFFF+1 wraps to 12'h000, no flag.
REQ-020 stall=1, br_taken=0: PC, ID_instruction, ID_pc, ID_valid all hold.
REQ-021 br_taken=1 in RUN: PC<=br_target, ID_instruction<=NOP_INSTR, ID_valid<=0, ID_pc<=PCAdd_pc (flush wrong-path word).
REQ-022 Priority: reset > br_taken > stall > normal fetch; br_taken with stall=1 still redirects and flushes.
REQ-023 RUN, no stall, no br_taken, M_instruction[15:12]=HALT_OPCODE: halt word latched into ID (ID_valid=1), PC held (not incremented), state<=HALTED.
REQ-024 Halt opcode under stall is not acted on until stall drops; halt under br_taken is discarded (redirect wins).
REQ-025 HALTED: PC holds, ID_instruction<=NOP_INSTR, ID_valid<=0 from next edge; stall and br_taken ignored.
REQ-026 Only reset leaves HALTED.

Reset
REQ-027 reset=1 at edge: PC<=RESET_PC, ID_instruction<=NOP_INSTR, ID_pc<=12'h000, ID_valid<=0, state<=RUN (halted=0), regardless of stall/br_taken/state.
REQ-028 Reset mid-stall or mid-halt aborts the operation; fetch resumes at RESET_PC on the first edge after reset deasserts.

Verification
REQ-029 Reset, then memory returns 16'h6011,16'h6242,16'h6443 at PC 0,1,2 -> after successive edges ID_pc=0,1,2, matching ID_instruction, ID_valid=1; PCAdd_pc=3.
REQ-030 stall=1 for 2 cycles with PCAdd_pc=3 -> PCAdd_pc stays 3, ID_instruction stays 16'h6443, ID_pc=2; fetch resumes at 3 after stall drops.
REQ-031 PCAdd_pc=5, stall=1, br_taken=1, br_target=12'h100 -> next PCAdd_pc=12'h100, ID_valid=0, ID_instruction=16'h0000; next edge fetches from 12'h100 with ID_valid=1.
REQ-032 PC forced to 12'hFFF via br_target, normal fetch -> ID_pc=12'hFFF, next PCAdd_pc=12'h000.
REQ-033 M_instruction=16'hF000 at PCAdd_pc=7 -> ID_instruction=16'hF000, ID_valid=1, halted=1, PCAdd_pc stays 7; following edge ID_valid=0; br_taken=1 then ignored; reset returns PCAdd_pc=0, halted=0.
REQ-034 reset=1 while stall=1 and ID_valid=1 -> next edge all outputs at REQ-027 values; stall then ignored until reset deasserts.
